// File: rtl/regfile_ctrl.sv
// Register-file write-back controller: scoreboard of in-flight destinations,
// round-robin arbitration between ALU and load-unit writebacks, registered write port.
module regfile_ctrl (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        iss_valid_i,
   input  logic [4:0]  iss_waddr_i,
   input  logic [4:0]  iss_rs_i,
   input  logic [4:0]  iss_rt_i,
   output logic        hazard_o,
   input  logic        wb0_valid_i,
   input  logic [4:0]  wb0_addr_i,
   input  logic [31:0] wb0_data_i,
   output logic        wb0_ready_o,
   input  logic        wb1_valid_i,
   input  logic [4:0]  wb1_addr_i,
   input  logic [31:0] wb1_data_i,
   output logic        wb1_ready_o,
   output logic        w_en_o,
   output logic [4:0]  waddr_o,
   output logic [31:0] data_in_o,
   output logic [31:0] pending_o
);

   logic [31:0] pending_q, pending_d;
   logic        last_grant_q, last_grant_d;
   logic        w_en_q, w_en_d;
   logic [4:0]  waddr_q, waddr_d;
   logic [31:0] data_q, data_d;

   logic        hazard;
   logic        dispatch_set;
   logic        gnt0, gnt1, any_gnt;
   logic [4:0]  acc_addr;
   logic [31:0] acc_data;

   // Read-after-write on either source, or write-after-write on the destination.
   assign hazard       = pending_q[iss_rs_i] | pending_q[iss_rt_i] |
                         (pending_q[iss_waddr_i] & iss_valid_i);
   assign dispatch_set = iss_valid_i & ~hazard & (iss_waddr_i != 5'd0);

   // last_grant_q = 1 means wb1 won most recently, so wb0 wins the next contention.
   assign gnt0    = wb0_valid_i & (~wb1_valid_i | last_grant_q);
   assign gnt1    = wb1_valid_i & (~wb0_valid_i | ~last_grant_q);
   assign any_gnt = gnt0 | gnt1;

   assign acc_addr = gnt1 ? wb1_addr_i : wb0_addr_i;
   assign acc_data = gnt1 ? wb1_data_i : wb0_data_i;

   always_comb begin
      last_grant_d = last_grant_q;
      w_en_d       = 1'b0;
      waddr_d      = waddr_q;
      data_d       = data_q;
      if (any_gnt) begin
         last_grant_d = gnt1;
         // A consumed request to r0 produces no write and leaves the port values alone.
         if (acc_addr != 5'd0) begin
            w_en_d  = 1'b1;
            waddr_d = acc_addr;
            data_d  = acc_data;
         end
      end
   end

   // Set wins over clear so a re-dispatch in the commit cycle stays tracked.
   assign pending_d[0] = 1'b0;
   generate
      for (genvar gi = 1; gi < 32; gi++) begin : g_pending
         logic set_bit, clr_bit;
         assign set_bit       = dispatch_set && (iss_waddr_i == 5'(gi));
         assign clr_bit       = w_en_q && (waddr_q == 5'(gi));
         assign pending_d[gi] = set_bit | (pending_q[gi] & ~clr_bit);
      end
   endgenerate

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pending_q    <= '0;
         last_grant_q <= 1'b1;
         w_en_q       <= 1'b0;
         waddr_q      <= '0;
         data_q       <= '0;
      end else begin
         pending_q    <= pending_d;
         last_grant_q <= last_grant_d;
         w_en_q       <= w_en_d;
         waddr_q      <= waddr_d;
         data_q       <= data_d;
      end
   end

   assign hazard_o    = hazard;
   assign wb0_ready_o = gnt0 & ~rst_i;
   assign wb1_ready_o = gnt1 & ~rst_i;
   assign w_en_o      = w_en_q;
   assign waddr_o     = waddr_q;
   assign data_in_o   = data_q;
   assign pending_o   = pending_q;

endmodule

// File: doc/regfile_ctrl.md
REGFILE_CTRL -- requirements
Module: regfile_ctrl

Interface
REQ-001 SHALL have ports: clock in 1 (single clock, all state on rising edge); reset in 1 (asynchronous, active-high).
REQ-002 SHALL have iss_valid in 1 (instruction dispatch strobe); iss_waddr in 5 (destination register of dispatched instruction).
REQ-003 SHALL have iss_rs in 5, iss_rt in 5 (source registers of instruction at dispatch); hazard out 1 (dispatch must stall).
REQ-004 SHALL have wb0_valid in 1, wb0_addr in 5, wb0_data in 32, wb0_ready out 1 (writeback requester 0, ALU).
REQ-005 SHALL have wb1_valid in 1, wb1_addr in 5, wb1_data in 32, wb1_ready out 1 (writeback requester 1, load unit).
REQ-006 SHALL have W_en out 1, Waddr out 5, Data_In out 32 (register file write port, registered outputs).
REQ-007 SHALL have pending out 32 (scoreboard, bit n = register n awaiting writeback).

Function
REQ-008 SHALL compute hazard combinationally = pending[iss_rs] | pending[iss_rt] | (pending[iss_waddr] & iss_valid).
REQ-009 SHALL set pending[iss_waddr] at the clock edge when iss_valid=1, hazard=0, and iss_waddr!=0; SHALL ignore iss_valid when hazard=1.
REQ-010 SHALL never set pending[0]; pending[0] SHALL read 0 at all times.
REQ-011 SHALL accept at most one writeback per cycle; wbN_ready SHALL be combinational and high only for the granted requester.
REQ-012 SHALL grant the sole valid requester when only one wbN_valid=1.
REQ-013 SHALL arbitrate round-robin when both are valid: grant the requester not granted most recently; last_grant register updates only on a grant.
REQ-014 SHALL hold both wbN_ready=0 when neither is valid.
REQ-015 SHALL, on accepting a request with addr!=0 at edge T, drive W_en=1, Waddr=addr, Data_In=data during cycle T+1 (latency 1).
REQ-016 SHALL, on accepting a request with addr=0, assert ready (request consumed) but keep W_en=0 in cycle T+1.
REQ-017 SHALL drive W_en=0 in any cycle following an edge with no accepted nonzero-address request; Waddr and Data_In SHALL hold their previous values.
REQ-018 SHALL clear pending[Waddr] at the edge ending a cycle with W_en=1 (the same edge at which the register file commits the write).
REQ-019 SHALL give set priority: when REQ-009 and REQ-018 target the same register at the same edge, the bit SHALL end at 1.
REQ-020 SHALL perform writebacks to non-pending registers normally; the pending bit stays 0.
REQ-021 SHALL cause a dispatch reading register n in the cycle after pending[n] clears to see hazard=0, with the register file already holding the written value.

Reset
REQ-022 SHALL, while reset=1 (asynchronously), force pending=0, W_en=0, Waddr=0, Data_In=0, and last_grant=1 (wb0 wins the first contention).
REQ-023 SHALL discard any request accepted in the cycle reset asserts; no write SHALL appear after reset deasserts.
REQ-024 SHALL drive wbN_ready=0 and hazard=0 whenever pending=0 and no wbN_valid, including during reset.

Verification
REQ-025 Dispatch iss_waddr=5 with no hazard -> pending=0x00000020 next cycle; iss_rs=5 then -> hazard=1, and iss_valid with iss_waddr=7 is ignored (pending unchanged).
REQ-026 wb0 and wb1 valid together for 4 cycles (addr 3/4, data 0x33/0x44) -> grants alternate wb0,wb1,wb0,wb1 starting with wb0; W_en=1 with Waddr 3,4,3,4 one cycle later.
REQ-027 wb0 addr=0, data=0xFFFFFFFF -> wb0_ready=1, W_en=0 next cycle, pending unchanged.
REQ-028 pending[9]=1, wb1 writes r9=0xABCD -> W_en=1/Waddr=9 at T+1, pending[9]=0 at T+2, iss_rs=9 at T+2 gives hazard=0 and the register file reads 0xABCD.
REQ-029 W_en=1 for r12 while iss_valid with iss_waddr=12 (hazard=0) in the same cycle -> pending[12]=1 after the edge.
REQ-030 reset pulsed mid-stream with pending=0xFFFFFFFE and both wb valid -> pending=0 and W_en=0 immediately; after release, the first contention is granted to wb0.
